tsu_gmii_tx_gearbox: RTL and testbench

- Egress counterpart of the TSU receive path: takes framed 32-bit words (sop/eop/mod) and serialises them onto GMII one byte per gmii_clk.
- Optionally inserts preamble/SFD and enforces a minimum inter-frame gap.
- Drives `tx_sfd`, a one-cycle pulse at the SFD byte (first data byte if no preamble). The TSU uses it as the egress time-stamp request.
- Aborts a frame with `gmii_err` on source underrun.

---
 rtl/tsu_pkg.sv | 26 ++
 rtl/tsu_gmii_tx_gearbox.sv | 248 ++++++++++++++++++++++++
 tb/tb_tsu_gmii_tx_gearbox.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsu_pkg.sv
// ---------------------------------------------------------------------------
// tsu_pkg
// Shared definitions for the TSU GMII transmit gearbox: GMII preamble/SFD
// byte values, preamble length, transmit FSM state encoding and a helper that
// turns the end-of-packet modulo field into a byte count.
// ---------------------------------------------------------------------------
package tsu_pkg;

    localparam logic [7:0] GMII_PREAMBLE = 8'h55;
    localparam logic [7:0] GMII_SFD      = 8'hD5;
    localparam int         PREAMBLE_LEN  = 7;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DISCARD,
        IFG
    } tx_state_e;

    // mod == 0 means a full word; otherwise mod bytes starting at [31:24].
    function automatic logic [2:0] eop_bytes(input logic [1:0] mod);
        return (mod == 2'd0) ? 3'd4 : {1'b0, mod};
    endfunction

endpackage

// File: rtl/tsu_gmii_tx_gearbox.sv
// ---------------------------------------------------------------------------
// tsu_gmii_tx_gearbox
// Serialises framed 32-bit words onto GMII, one byte per gmii_clk, with
// optional preamble/SFD insertion and a minimum inter-frame gap. Pulses
// tx_sfd on the SFD byte (or the first data byte without preamble) as the
// egress time-stamp request, and aborts a frame with TX_ER on source underrun.
//
// Ports:
//   gmii_clk     single clock
//   rst          synchronous active-high reset
//   in_valid     input word valid
//   in_ready     word accepted this cycle when in_valid is also high
//   in_data      frame word, [31:24] transmitted first
//   in_sop       first word of frame
//   in_eop       last word of frame
//   in_mod       valid bytes in the eop word (0 = 4)
//   gmii_ctrl    GMII TX_EN
//   gmii_err     GMII TX_ER
//   gmii_data    GMII TXD
//   tx_sfd       one-cycle time-stamp request pulse
//   tx_underrun  one-cycle pulse when a frame is aborted
// ---------------------------------------------------------------------------
module tsu_gmii_tx_gearbox
    import tsu_pkg::*;
#(
    parameter bit          PREAMBLE_EN = 1'b1,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        gmii_clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [1:0]  in_mod,
    output logic        gmii_ctrl,
    output logic        gmii_err,
    output logic [7:0]  gmii_data,
    output logic        tx_sfd,
    output logic        tx_underrun
);

    localparam logic [7:0] PREAMBLE_LAST = 8'(PREAMBLE_LEN);
    localparam logic [7:0] IFG_LAST      = 8'(IFG_CYCLES - 1);

    // DISCARD phases held in byte_idx: emit the error byte, let it go out,
    // then drain the source with the line idle.
    localparam logic [1:0] DISC_ERR   = 2'd0;
    localparam logic [1:0] DISC_WAIT  = 2'd1;
    localparam logic [1:0] DISC_DRAIN = 2'd2;

    tx_state_e   state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [1:0]  last_idx_q, last_idx_d;
    logic        eop_q, eop_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        gmii_ctrl_q, gmii_ctrl_d;
    logic        gmii_err_q, gmii_err_d;
    logic [7:0]  gmii_data_q, gmii_data_d;
    logic        tx_sfd_q, tx_sfd_d;
    logic        tx_underrun_q, tx_underrun_d;

    logic        ready_raw;
    logic        accept;
    logic [1:0]  in_last_idx;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Index of the final byte of the word being offered.
    assign in_last_idx = in_eop ? 2'(eop_bytes(in_mod) - 3'd1) : 2'd3;

    // Ready depends only on state and byte position. In DATA the next word is
    // taken while the current final byte is being loaded into the output
    // register, so the new word's first byte follows with no gap.
    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            IDLE:    ready_raw = 1'b1;
            DATA:    ready_raw = (byte_idx_q == last_idx_q) && !eop_q;
            DISCARD: ready_raw = (byte_idx_q == DISC_DRAIN);
            default: ready_raw = 1'b0;
        endcase
    end

    assign in_ready = ready_raw & ~rst;
    assign accept   = in_valid & ready_raw;

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so everything here describes the byte driven next cycle.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        last_idx_d    = last_idx_q;
        eop_d         = eop_q;
        word_d        = word_q;
        cnt_d         = cnt_q;
        gmii_ctrl_d   = 1'b0;
        gmii_err_d    = 1'b0;
        gmii_data_d   = 8'h00;
        tx_sfd_d      = 1'b0;
        tx_underrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-sop words are consumed and dropped.
                if (accept && in_sop) begin
                    word_d      = in_data;
                    eop_d       = in_eop;
                    last_idx_d  = in_last_idx;
                    gmii_ctrl_d = 1'b1;
                    if (PREAMBLE_EN) begin
                        gmii_data_d = GMII_PREAMBLE;
                        cnt_d       = 8'd1;
                        byte_idx_d  = 2'd0;
                        state_d     = PREAMBLE;
                    end else begin
                        gmii_data_d = in_data[31:24];
                        tx_sfd_d    = 1'b1;
                        if (in_last_idx == 2'd0) begin
                            cnt_d   = 8'd0;
                            state_d = IFG;
                        end else begin
                            byte_idx_d = 2'd1;
                            state_d    = DATA;
                        end
                    end
                end
            end

            PREAMBLE: begin
                gmii_ctrl_d = 1'b1;
                if (cnt_q < PREAMBLE_LAST) begin
                    gmii_data_d = GMII_PREAMBLE;
                    cnt_d       = cnt_q + 8'd1;
                end else begin
                    gmii_data_d = GMII_SFD;
                    tx_sfd_d    = 1'b1;
                    byte_idx_d  = 2'd0;
                    state_d     = DATA;
                end
            end

            DATA: begin
                gmii_ctrl_d = 1'b1;
                gmii_data_d = word_byte(word_q, byte_idx_q);
                if (byte_idx_q == last_idx_q) begin
                    if (eop_q) begin
                        cnt_d   = 8'd0;
                        state_d = IFG;
                    end else if (accept) begin
                        word_d     = in_data;
                        eop_d      = in_eop;
                        last_idx_d = in_last_idx;
                        byte_idx_d = 2'd0;
                    end else begin
                        byte_idx_d = DISC_ERR;
                        state_d    = DISCARD;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end

            DISCARD: begin
                case (byte_idx_q)
                    DISC_ERR: begin
                        gmii_ctrl_d   = 1'b1;
                        gmii_err_d    = 1'b1;
                        tx_underrun_d = 1'b1;
                        byte_idx_d    = DISC_WAIT;
                    end
                    DISC_WAIT: byte_idx_d = DISC_DRAIN;
                    default: begin
                        if (accept && in_eop) begin
                            cnt_d   = 8'd0;
                            state_d = IFG;
                        end
                    end
                endcase
            end

            IFG: begin
                // The state spans IFG_CYCLES cycles starting with the one in
                // which the last byte is on the wire, so the line is low for
                // exactly IFG_CYCLES cycles before the next preamble.
                if (cnt_q == IFG_LAST) begin
                    cnt_d      = 8'd0;
                    byte_idx_d = 2'd0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset truncates any frame without TX_ER.
    always_ff @(posedge gmii_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            byte_idx_q    <= 2'd0;
            last_idx_q    <= 2'd0;
            eop_q         <= 1'b0;
            word_q        <= 32'h0;
            cnt_q         <= 8'd0;
            gmii_ctrl_q   <= 1'b0;
            gmii_err_q    <= 1'b0;
            gmii_data_q   <= 8'h00;
            tx_sfd_q      <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            last_idx_q    <= last_idx_d;
            eop_q         <= eop_d;
            word_q        <= word_d;
            cnt_q         <= cnt_d;
            gmii_ctrl_q   <= gmii_ctrl_d;
            gmii_err_q    <= gmii_err_d;
            gmii_data_q   <= gmii_data_d;
            tx_sfd_q      <= tx_sfd_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign gmii_ctrl   = gmii_ctrl_q;
    assign gmii_err    = gmii_err_q;
    assign gmii_data   = gmii_data_q;
    assign tx_sfd      = tx_sfd_q;
    assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_tsu_gmii_tx_gearbox.sv
// ---------------------------------------------------------------------------
// tb_tsu_gmii_tx_gearbox
// Directed bench for the GMII transmit gearbox: one instance with preamble,
// one without. Every output cycle is logged as
// {tx_underrun, gmii_err, gmii_ctrl, tx_sfd, gmii_data} and compared against
// hand-written expected byte sequences.
// ---------------------------------------------------------------------------
module tb_tsu_gmii_tx_gearbox;

    logic        gmii_clk = 1'b0;
    logic        rst      = 1'b1;

    logic        in_valid, in_ready, in_sop, in_eop;
    logic [31:0] in_data;
    logic [1:0]  in_mod;
    logic        gmii_ctrl, gmii_err, tx_sfd, tx_underrun;
    logic [7:0]  gmii_data;

    logic        np_in_valid, np_in_ready, np_in_sop, np_in_eop;
    logic [31:0] np_in_data;
    logic [1:0]  np_in_mod;
    logic        np_gmii_ctrl, np_gmii_err, np_tx_sfd, np_tx_underrun;
    logic [7:0]  np_gmii_data;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [11:0] log_q[$];
    logic [11:0] np_log_q[$];
    logic [11:0] exp_q[$];

    always #5 gmii_clk = ~gmii_clk;

    tsu_gmii_tx_gearbox #(.PREAMBLE_EN(1'b1), .IFG_CYCLES(12)) dut (
        .gmii_clk    (gmii_clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sop      (in_sop),
        .in_eop      (in_eop),
        .in_mod      (in_mod),
        .gmii_ctrl   (gmii_ctrl),
        .gmii_err    (gmii_err),
        .gmii_data   (gmii_data),
        .tx_sfd      (tx_sfd),
        .tx_underrun (tx_underrun)
    );

    tsu_gmii_tx_gearbox #(.PREAMBLE_EN(1'b0), .IFG_CYCLES(12)) dut_np (
        .gmii_clk    (gmii_clk),
        .rst         (rst),
        .in_valid    (np_in_valid),
        .in_ready    (np_in_ready),
        .in_data     (np_in_data),
        .in_sop      (np_in_sop),
        .in_eop      (np_in_eop),
        .in_mod      (np_in_mod),
        .gmii_ctrl   (np_gmii_ctrl),
        .gmii_err    (np_gmii_err),
        .gmii_data   (np_gmii_data),
        .tx_sfd      (np_tx_sfd),
        .tx_underrun (np_tx_underrun)
    );

    // Log every output cycle away from the active edge.
    always @(negedge gmii_clk) begin
        if (!rst) begin
            log_q.push_back({tx_underrun, gmii_err, gmii_ctrl, tx_sfd, gmii_data});
            np_log_q.push_back({np_tx_underrun, np_gmii_err, np_gmii_ctrl, np_tx_sfd, np_gmii_data});
        end
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] rec(input bit u, input bit e, input bit c, input bit s,
                                        input logic [7:0] d);
        return {u, e, c, s, d};
    endfunction

    function automatic logic [11:0] entryAt(input bit np, input int i);
        if (np) return (i >= 0 && i < np_log_q.size()) ? np_log_q[i] : 12'hFFF;
        return (i >= 0 && i < log_q.size()) ? log_q[i] : 12'hFFF;
    endfunction

    function automatic int countBit(input bit np, input int bitpos);
        int n = 0;
        int sz = np ? np_log_q.size() : log_q.size();
        logic [11:0] e;
        for (int i = 0; i < sz; i++) begin
            e = entryAt(np, i);
            if (e[bitpos]) n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one word and hold it until the selected DUT takes it; in_valid is
    // left high so back-to-back calls keep the source sustained.
    task automatic applyStimulus(input bit np, input logic [31:0] d, input bit sop,
                                 input bit eop, input logic [1:0] mod);
        int  waited = 0;
        bit  done   = 1'b0;
        bit  rdy;
        if (np) begin
            np_in_valid = 1'b1; np_in_data = d; np_in_sop = sop; np_in_eop = eop; np_in_mod = mod;
        end else begin
            in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop; in_mod = mod;
        end
        while (!done && waited < 200) begin
            @(negedge gmii_clk);
            rdy = np ? np_in_ready : in_ready;
            if (rdy) done = 1'b1;
            else waited++;
        end
        checkOutput($sformatf("handshake 0x%08h", d), 32'(done), 32'd1);
        @(posedge gmii_clk);
        #1;
        if (!done) begin
            in_valid    = 1'b0;
            np_in_valid = 1'b0;
        end
    endtask

    task automatic pushPreamble();
        for (int i = 0; i < 7; i++) exp_q.push_back(rec(0, 0, 1, 0, 8'h55));
        exp_q.push_back(rec(0, 0, 1, 1, 8'hD5));
    endtask

    // Locate the first ctrl-high entry at or after 'from' and compare the
    // following entries against exp_q.
    task automatic checkFrame(input string tag, input bit np, input int from, output int first);
        int f  = -1;
        int sz = np ? np_log_q.size() : log_q.size();
        logic [11:0] e;
        for (int i = from; i < sz; i++) begin
            e = entryAt(np, i);
            if (f < 0 && e[9]) f = i;
        end
        checkOutput($sformatf("%s start", tag), 32'(f >= 0), 32'd1);
        if (f < 0) f = from;
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("%s entry%0d", tag, i), 32'(entryAt(np, f + i)), 32'(exp_q[i]));
        first = f;
    endtask

    initial begin
        int  fa, fb, fx;
        bit  found;

        in_valid = 0; in_data = 0; in_sop = 0; in_eop = 0; in_mod = 0;
        np_in_valid = 0; np_in_data = 0; np_in_sop = 0; np_in_eop = 0; np_in_mod = 0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge gmii_clk);
        @(negedge gmii_clk);
        checkOutput("reset outputs", 32'({tx_underrun, gmii_err, gmii_ctrl, tx_sfd, gmii_data}), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        @(posedge gmii_clk); #1;
        rst = 1'b0;
        @(negedge gmii_clk);
        checkOutput("idle in_ready", 32'(in_ready), 32'd1);

        // Sustained two-word frame followed by a one-word frame
        @(posedge gmii_clk); #1;
        log_q.delete(); np_log_q.delete();
        applyStimulus(0, 32'h01020304, 1, 0, 2'd0);
        applyStimulus(0, 32'h05060708, 0, 1, 2'd0);
        applyStimulus(0, 32'h0A0B0C0D, 1, 1, 2'd0);
        in_valid = 1'b0;
        repeat (40) @(posedge gmii_clk); #1;
        exp_q.delete();
        pushPreamble();
        for (int b = 1; b <= 8; b++) exp_q.push_back(rec(0, 0, 1, 0, 8'(b)));
        checkFrame("frameA", 0, 0, fa);
        exp_q.delete();
        pushPreamble();
        exp_q.push_back(rec(0, 0, 1, 0, 8'h0A));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h0B));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h0C));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h0D));
        checkFrame("frameB", 0, fa + 16, fb);
        checkOutput("ifg gap", 32'(fb - (fa + 15)), 32'd13);
        checkOutput("sustained ctrl count", 32'(countBit(0, 9)), 32'd28);
        checkOutput("sustained sfd count", 32'(countBit(0, 8)), 32'd2);

        // No-preamble single short word
        log_q.delete(); np_log_q.delete();
        applyStimulus(1, 32'hAABBCCDD, 1, 1, 2'd3);
        np_in_valid = 1'b0;
        repeat (20) @(posedge gmii_clk); #1;
        exp_q.delete();
        exp_q.push_back(rec(0, 0, 1, 1, 8'hAA));
        exp_q.push_back(rec(0, 0, 1, 0, 8'hBB));
        exp_q.push_back(rec(0, 0, 1, 0, 8'hCC));
        checkFrame("nopre", 1, 0, fx);
        checkOutput("nopre ctrl count", 32'(countBit(1, 9)), 32'd3);

        // Underrun then discard of the rest of the frame
        log_q.delete(); np_log_q.delete();
        applyStimulus(0, 32'h11223344, 1, 0, 2'd0);
        in_valid = 1'b0;
        repeat (20) @(posedge gmii_clk); #1;
        applyStimulus(0, 32'h99999999, 0, 0, 2'd0);
        applyStimulus(0, 32'h77777777, 0, 1, 2'd1);
        in_valid = 1'b0;
        @(negedge gmii_clk);
        checkOutput("discard->ifg in_ready", 32'(in_ready), 32'd0);
        repeat (20) @(posedge gmii_clk); #1;
        @(negedge gmii_clk);
        checkOutput("after discard idle in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        pushPreamble();
        exp_q.push_back(rec(0, 0, 1, 0, 8'h11));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h22));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h33));
        exp_q.push_back(rec(0, 0, 1, 0, 8'h44));
        exp_q.push_back(rec(1, 1, 1, 0, 8'h00));
        checkFrame("underrun", 0, 0, fx);
        checkOutput("underrun ctrl count", 32'(countBit(0, 9)), 32'd13);
        checkOutput("underrun pulse count", 32'(countBit(0, 11)), 32'd1);

        // Non-sop word in IDLE is dropped
        @(posedge gmii_clk); #1;
        log_q.delete(); np_log_q.delete();
        applyStimulus(0, 32'hDEADBEEF, 0, 0, 2'd0);
        in_valid = 1'b0;
        repeat (20) @(posedge gmii_clk); #1;
        checkOutput("nonsop ctrl count", 32'(countBit(0, 9)), 32'd0);
        checkOutput("nonsop sfd count", 32'(countBit(0, 8)), 32'd0);
        @(negedge gmii_clk);
        checkOutput("nonsop still idle", 32'(in_ready), 32'd1);

        // Reset in the middle of a frame, then a fresh frame
        @(posedge gmii_clk); #1;
        applyStimulus(0, 32'h01020304, 1, 0, 2'd0);
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge gmii_clk);
            if (gmii_ctrl && gmii_data == 8'h03) found = 1'b1;
        end
        checkOutput("saw byte 03", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge gmii_clk); #1;
        rst = 1'b0;
        @(negedge gmii_clk);
        checkOutput("rst midframe outputs",
                    32'({tx_underrun, gmii_err, gmii_ctrl, tx_sfd, gmii_data}), 32'd0);
        log_q.delete(); np_log_q.delete();
        repeat (20) @(posedge gmii_clk); #1;
        checkOutput("post-rst ctrl count", 32'(countBit(0, 9)), 32'd0);
        checkOutput("post-rst err count", 32'(countBit(0, 10)), 32'd0);
        log_q.delete(); np_log_q.delete();
        applyStimulus(0, 32'hA1A2A3A4, 1, 1, 2'd2);
        in_valid = 1'b0;
        repeat (20) @(posedge gmii_clk); #1;
        exp_q.delete();
        pushPreamble();
        exp_q.push_back(rec(0, 0, 1, 0, 8'hA1));
        exp_q.push_back(rec(0, 0, 1, 0, 8'hA2));
        checkFrame("after rst", 0, 0, fx);
        checkOutput("after rst ctrl count", 32'(countBit(0, 9)), 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
